// File: rtl/ram_boot_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : ram_boot_loader
// Purpose  : Framed serial boot loader; writes payload to program RAM and
//            holds the CPU until a frame with a good checksum has landed.
// Revision : 1.0 - initial release
// ============================================================================
module ram_boot_loader #(
  parameter int unsigned           ADDR_WIDTH = 12,
  parameter logic [7:0]            SYNC_BYTE  = 8'h55,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_data,
  output logic                  mem_we,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CSUM   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                  r_state;
  logic [3:0]              r_len_hi;
  logic [11:0]             r_len;
  logic [11:0]             r_count;
  logic [7:0]              r_csum;

  logic                    w_accept;
  logic [11:0]             w_len;
  logic [11:0]             w_count_next;
  logic [7:0]              w_csum_next;
  logic [ADDR_WIDTH-1:0]   w_wr_addr;

  // DONE is terminal, so the loader stops accepting bytes once it gets there
  assign rx_ready     = (r_state != S_DONE);
  assign w_accept     = rx_valid && rx_ready;
  assign w_len        = {r_len_hi, rx_data};
  assign w_count_next = r_count + 12'd1;
  assign w_csum_next  = r_csum + rx_data;
  // Wraps naturally at the top of the address space
  assign w_wr_addr    = BASE_ADDR + ADDR_WIDTH'(r_count);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_len_hi <= 4'h0;
      r_len    <= 12'd0;
      r_count  <= 12'd0;
      r_csum   <= 8'h00;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= 8'h00;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (w_accept) begin
        unique case (r_state)
          S_IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              r_state <= S_LEN_HI;
              error   <= 1'b0;
            end
          end
          S_LEN_HI: begin
            if (rx_data[7:4] != 4'h0) begin
              error   <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_len_hi <= rx_data[3:0];
              r_state  <= S_LEN_LO;
            end
          end
          S_LEN_LO: begin
            r_len   <= w_len;
            r_count <= 12'd0;
            r_csum  <= 8'h00;
            r_state <= (w_len == 12'd0) ? S_CSUM : S_DATA;
          end
          S_DATA: begin
            mem_we   <= 1'b1;
            mem_addr <= w_wr_addr;
            mem_data <= rx_data;
            r_csum   <= w_csum_next;
            r_count  <= w_count_next;
            if (w_count_next == r_len) begin
              r_state <= S_CSUM;
            end
          end
          S_CSUM: begin
            if (rx_data == r_csum) begin
              r_state  <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              error   <= 1'b1;
              r_state <= S_IDLE;
            end
          end
          default: begin
            r_state <= r_state;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_boot_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ram_boot_loader
// Purpose  : Scoreboard bench for ram_boot_loader (BASE_ADDR 0 and FFE).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_boot_loader;

  localparam int N = 2;

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  data;
    int          cyc;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset    [N];
  logic [7:0]  rx_data  [N];
  logic        rx_valid [N];
  logic        rx_ready [N];
  logic [11:0] mem_addr [N];
  logic [7:0]  mem_data [N];
  logic        mem_we   [N];
  logic        cpu_hold [N];
  logic        done     [N];
  logic        error    [N];

  int  cyc     = 0;
  int  n_tests = 0;
  int  n_fail  = 0;
  wr_t exp_q0[$];
  wr_t exp_q1[$];
  bit [7:0] ram     [N][4096];
  bit [7:0] exp_ram [N][4096];
  bit       exp_done  [N];
  bit       exp_error [N];
  logic [7:0] pl[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_boot_loader u_dut0 (
    .clk(clk), .reset(reset[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
    .rx_ready(rx_ready[0]), .mem_addr(mem_addr[0]), .mem_data(mem_data[0]),
    .mem_we(mem_we[0]), .cpu_hold(cpu_hold[0]), .done(done[0]), .error(error[0])
  );

  ram_boot_loader #(.BASE_ADDR(12'hFFE)) u_dut1 (
    .clk(clk), .reset(reset[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
    .rx_ready(rx_ready[1]), .mem_addr(mem_addr[1]), .mem_data(mem_data[1]),
    .mem_we(mem_we[1]), .cpu_hold(cpu_hold[1]), .done(done[1]), .error(error[1])
  );

  // Downstream program RAM
  always @(posedge clk) begin
    for (int u = 0; u < N; u++)
      if (mem_we[u] === 1'b1) ram[u][mem_addr[u]] <= mem_data[u];
  end

  // Monitor: every write pulse must match the oldest expected write, cycle-exact
  task automatic check_write(input int u);
    wr_t e;
    n_tests++;
    if ((u == 0 && exp_q0.size() == 0) || (u == 1 && exp_q1.size() == 0)) begin
      n_fail++;
      $display("FAIL unexpected_write u%0d: got addr=%h data=%h cyc=%0d, required no write",
               u, mem_addr[u], mem_data[u], cyc);
      return;
    end
    if (u == 0) e = exp_q0.pop_front();
    else        e = exp_q1.pop_front();
    if (mem_addr[u] !== e.addr || mem_data[u] !== e.data || cyc != e.cyc) begin
      n_fail++;
      $display("FAIL write u%0d: got addr=%h data=%h cyc=%0d, expected addr=%h data=%h cyc=%0d",
               u, mem_addr[u], mem_data[u], cyc, e.addr, e.data, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    for (int u = 0; u < N; u++)
      if (mem_we[u] === 1'b1) check_write(u);
  end

  function automatic logic [11:0] base_of(input int u);
    return (u == 0) ? 12'h000 : 12'hFFE;
  endfunction

  function automatic int rgap(input int mx);
    return (mx == 0) ? 0 : int'($urandom_range(0, mx));
  endfunction

  task automatic chk(input string name, input int u, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s u%0d: got %0h, expected %0h", name, u, act, expv);
    end
  endtask

  task automatic chk_status(input string name, input int u);
    chk({name, "_done"},     u, 32'(done[u]),     32'(exp_done[u]));
    chk({name, "_error"},    u, 32'(error[u]),    32'(exp_error[u]));
    chk({name, "_cpu_hold"}, u, 32'(cpu_hold[u]), 32'(!exp_done[u]));
    chk({name, "_rx_ready"}, u, 32'(rx_ready[u]), 32'(!exp_done[u]));
  endtask

  task automatic chk_reset(input string name, input int u);
    chk({name, "_rx_ready"}, u, 32'(rx_ready[u]), 32'd1);
    chk({name, "_cpu_hold"}, u, 32'(cpu_hold[u]), 32'd1);
    chk({name, "_done"},     u, 32'(done[u]),     32'd0);
    chk({name, "_error"},    u, 32'(error[u]),    32'd0);
    chk({name, "_mem_we"},   u, 32'(mem_we[u]),   32'd0);
    chk({name, "_mem_addr"}, u, 32'(mem_addr[u]), 32'd0);
    chk({name, "_mem_data"}, u, 32'(mem_data[u]), 32'd0);
  endtask

  task automatic push(input int u, input logic [11:0] a, input logic [7:0] d);
    wr_t w;
    w.addr = a; w.data = d; w.cyc = cyc + 1;
    if (u == 0) exp_q0.push_back(w);
    else        exp_q1.push_back(w);
    exp_ram[u][a] = d;
  endtask

  // All drive tasks start and end 1 ns after a rising edge
  task automatic idle(input int u, input int n);
    rx_valid[u] = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input int u, input logic [7:0] b, input bit wr,
                      input logic [11:0] a, input int gap);
    rx_data[u]  = b;
    rx_valid[u] = 1'b1;
    if (wr) push(u, a, b);
    @(posedge clk); #1;
    if (gap > 0) idle(u, gap);
  endtask

  // Sends SYNC, LEN, payload from pl[], and a good or corrupted checksum
  task automatic send_frame(input string name, input int u, input bit bad, input int mx);
    logic [11:0] len;
    logic [7:0]  s;
    logic [7:0]  c;
    len = 12'(pl.size());
    s   = 8'h00;
    send(u, 8'h55, 1'b0, 12'h0, rgap(mx));
    chk({name, "_sync_clears_error"}, u, 32'(error[u]), 32'd0);
    send(u, {4'h0, len[11:8]}, 1'b0, 12'h0, rgap(mx));
    send(u, len[7:0], 1'b0, 12'h0, rgap(mx));
    for (int i = 0; i < pl.size(); i++) begin
      send(u, pl[i], 1'b1, base_of(u) + 12'(i), rgap(mx));
      s = s + pl[i];
    end
    c = bad ? (s + 8'($urandom_range(1, 255))) : s;
    send(u, c, 1'b0, 12'h0, 0);
    rx_valid[u] = 1'b0;
    exp_done[u]  = !bad;
    exp_error[u] = bad;
    chk_status(name, u);
  endtask

  task automatic do_reset(input string name, input int u);
    #2;
    reset[u] = 1'b1;
    #1;
    chk_reset({name, "_async"}, u);
    @(posedge clk); #1;
    reset[u] = 1'b0;
    exp_done[u]  = 1'b0;
    exp_error[u] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int u;
    bit bad;
    for (int i = 0; i < N; i++) begin
      reset[i] = 1'b1; rx_valid[i] = 1'b0; rx_data[i] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) chk_reset("reset", i);
    for (int i = 0; i < N; i++) reset[i] = 1'b0;
    idle(0, 1);

    // Basic frame
    pl = '{8'hE1, 8'h01, 8'h54};
    send_frame("t1", 0, 1'b0, 1);
    // A byte offered after DONE must be ignored
    send(0, 8'h55, 1'b0, 12'h0, 0);
    send(0, 8'h12, 1'b0, 12'h0, 0);
    idle(0, 2);
    chk_status("t1_after_done", 0);
    do_reset("t1", 0);

    // Rejected frame, then recovery
    pl = '{8'hAA, 8'hBB};
    send_frame("t2_bad", 0, 1'b1, 0);
    idle(0, 2);
    chk("t2_ram0", 0, 32'(ram[0][0]), 32'h00AA);
    chk("t2_ram1", 0, 32'(ram[0][1]), 32'h00BB);
    pl = '{8'h7F};
    send_frame("t2_good", 0, 1'b0, 0);
    idle(0, 2);
    do_reset("t2", 0);

    // Leading garbage with rx_valid held high throughout
    send(0, 8'h00, 1'b0, 12'h0, 0);
    send(0, 8'hFF, 1'b0, 12'h0, 0);
    send(0, 8'h12, 1'b0, 12'h0, 0);
    pl = '{8'h55, 8'h10, 8'hC3, 8'h09};
    send_frame("t3", 0, 1'b0, 0);
    idle(0, 2);
    do_reset("t3", 0);

    // Address wrap at top of RAM
    pl = '{8'h01, 8'h02, 8'h03};
    send_frame("t4", 1, 1'b0, 1);
    idle(1, 2);
    chk("t4_ram_fff", 1, 32'(ram[1][12'hFFF]), 32'h0002);
    chk("t4_ram_000", 1, 32'(ram[1][12'h000]), 32'h0003);
    do_reset("t4", 1);

    // Bad length high nibble, then a zero-length frame
    send(0, 8'h55, 1'b0, 12'h0, 0);
    send(0, 8'h10, 1'b0, 12'h0, 0);
    rx_valid[0] = 1'b0;
    exp_error[0] = 1'b1;
    chk_status("t5_badlen", 0);
    pl = {};
    send_frame("t5_zero", 0, 1'b0, 0);
    idle(0, 2);
    do_reset("t5", 0);

    // Reset part-way through a 4-byte frame
    send(0, 8'h55, 1'b0, 12'h0, 0);
    send(0, 8'h00, 1'b0, 12'h0, 0);
    send(0, 8'h04, 1'b0, 12'h0, 0);
    send(0, 8'h3C, 1'b1, 12'h000, 0);
    send(0, 8'hA5, 1'b1, 12'h001, 0);
    idle(0, 1);
    do_reset("t6", 0);
    idle(0, 1);
    chk("t6_ram0", 0, 32'(ram[0][0]), 32'h003C);
    chk("t6_ram1", 0, 32'(ram[0][1]), 32'h00A5);
    pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_frame("t6_after", 0, 1'b0, 1);
    idle(0, 2);
    do_reset("t6b", 0);

    // Randomized frames on both instances
    for (int k = 0; k < 30; k++) begin
      u = k % 2;
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        logic [7:0] gb;
        gb = 8'($urandom_range(0, 255));
        if (gb == 8'h55) gb = 8'h56;
        send(u, gb, 1'b0, 12'h0, rgap(1));
      end
      if ($urandom_range(0, 9) == 0) begin
        send(u, 8'h55, 1'b0, 12'h0, 0);
        send(u, 8'($urandom_range(16, 255)), 1'b0, 12'h0, 0);
        rx_valid[u] = 1'b0;
        exp_error[u] = 1'b1;
        chk_status("rand_badlen", u);
      end
      pl = {};
      for (int i = 0; i < int'((u == 0) ? $urandom_range(1, 24) : $urandom_range(0, 6)); i++)
        pl.push_back(8'($urandom_range(0, 255)));
      bad = ($urandom_range(0, 3) == 0);
      send_frame("rand", u, bad, int'($urandom_range(0, 2)));
      idle(u, 2);
      if (exp_done[u]) do_reset("rand", u);
    end

    // Maximum-length frame
    if (exp_done[0]) do_reset("pre_max", 0);
    pl = {};
    for (int i = 0; i < 4095; i++) pl.push_back(8'($urandom_range(0, 255)));
    send_frame("maxlen", 0, 1'b0, 0);
    idle(0, 3);
    idle(1, 0);

    chk("queue_empty", 0, 32'(exp_q0.size()), 32'd0);
    chk("queue_empty", 1, 32'(exp_q1.size()), 32'd0);
    for (int v = 0; v < N; v++) begin
      int bad_at;
      bad_at = -1;
      for (int a = 0; a < 4096; a++)
        if (bad_at < 0 && ram[v][a] != exp_ram[v][a]) bad_at = a;
      chk("ram_image_first_diff", v, 32'(bad_at), 32'hFFFF_FFFF);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_boot_loader.md
Name: ram_boot_loader

Overview:
Serial-stream boot loader that sits directly upstream of the 4 KB synchronous program RAM. It accepts a framed byte stream from the UART receiver and writes the payload into RAM while holding the CPU in reset. It releases the CPU once a frame with a valid checksum has been written. While cpu_hold is high, the loader's mem_* outputs own the RAM port; the top-level mux selects them.

Parameters:
ADDR_WIDTH, 12, RAM address width; 4096-byte address space
SYNC_BYTE, 8'h55, frame start marker
BASE_ADDR, 12'h000, RAM address of the first payload byte

Ports:
clk  in  1  system clock; all state changes on posedge clk
reset  in  1  asynchronous, active-high reset
rx_data  in  8  received byte
rx_valid  in  1  rx_data is valid this cycle
rx_ready  out  1  loader accepts a byte this cycle
mem_addr  out  ADDR_WIDTH  RAM write address
mem_data  out  8  RAM write data
mem_we  out  1  RAM write enable, one-cycle pulse per payload byte
cpu_hold  out  1  holds the CPU in reset and gives the loader the RAM port
done  out  1  load completed successfully; sticky until reset
error  out  1  last frame was rejected

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, mem_we=0, mem_addr=0, mem_data=0, cpu_hold=1, done=0, error=0, byte counter=0, checksum=0.
- A byte is accepted when rx_valid && rx_ready on a clock edge.
- rx_ready = (state != DONE). It is combinational from state, so it is 1 immediately after reset.
- Frame format: SYNC_BYTE, LEN_HI, LEN_LO, LEN payload bytes, CSUM.
  - LEN = {LEN_HI[3:0], LEN_LO}, a 12-bit value.
  - CSUM = sum of the payload bytes mod 256.
- States and transitions:
  - IDLE: accepted byte == SYNC_BYTE -> LEN_HI, and error is cleared. Any other byte is discarded and the state stays IDLE.
  - LEN_HI: if byte[7:4] != 0 -> error=1, go to IDLE. Otherwise latch byte[3:0] -> LEN_LO.
  - LEN_LO: latch the low byte, clear counter and checksum. If LEN == 0 -> CSUM, else -> DATA.
  - DATA: for each accepted byte, register a write for the next cycle: mem_we=1, mem_addr=(BASE_ADDR+counter) mod 2^ADDR_WIDTH, mem_data=byte. Then checksum += byte (8-bit wrap) and counter += 1. When counter reaches LEN -> CSUM.
  - CSUM: if byte == checksum -> DONE. Otherwise error=1 -> IDLE.
  - DONE: done=1, cpu_hold=0, rx_ready=0. Terminal until reset.
- Write latency: exactly 1 cycle from byte acceptance to the mem_we pulse.
  - Back-to-back accepted bytes produce back-to-back write pulses at consecutive addresses.
  - mem_we is 0 in every cycle that does not follow a DATA-state acceptance.
- mem_addr and mem_data hold their last values when mem_we=0.
- Address wrap: BASE_ADDR+LEN beyond 4095 wraps to 0. No error is raised.
- A maximum-length frame (LEN=4095) is legal.
- The RAM port is write-only from the loader; the RAM's data_out is unused by this block.
- Idle gaps (rx_valid=0) are allowed anywhere in a frame. There is no timeout.
- Sync inside a frame: a SYNC_BYTE value in LEN or payload positions is treated as data and does not restart the frame.
- Rejected frame: bytes already written stay in RAM. cpu_hold stays 1. A new frame fully overwrites its target range.
- cpu_hold falls in the same cycle that done rises.
- Reset mid-frame: returns to IDLE immediately. Partial RAM contents are retained and cpu_hold=1.

Test Plan:
1. Reset, then send 55 00 03 E1 01 54 36 -> mem_we pulses at addresses 0,1,2 with data E1,01,54 one cycle after each accept; done=1, cpu_hold=0, rx_ready=0; error=0.
2. Send 55 00 02 AA BB 00 (bad checksum, correct is 65) -> two writes, error=1, cpu_hold=1. Then send 55 00 01 7F 7F -> error clears on the sync byte, done=1.
3. Leading garbage 00 FF 12 before a valid frame with rx_valid held high continuously -> garbage produces no writes; frame writes back-to-back, one write per cycle.
4. BASE_ADDR=12'hFFE, frame 55 00 03 01 02 03 06 -> writes to FFE, FFF, 000; done=1.
5. Send 55 10 .. (LEN_HI upper nibble nonzero) -> error=1, return to IDLE, no writes. Send 55 00 00 00 -> done=1 with zero writes.
6. Assert reset after the 2nd payload byte of a 4-byte frame -> outputs return to reset values asynchronously and state=IDLE. The 2 written bytes remain in RAM; a subsequent valid frame completes normally.
